// File: rtl/sseg_scan_display.sv
// Time-multiplexed seven-segment driver for DIGITS common-anode digits.
// Double-buffered digit/dp/blank/blink registers commit only at the frame boundary.
module sseg_scan_display #(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned SIM          = 0,
    parameter int unsigned SIM_DIV      = 4,
    parameter int unsigned BLINK_FRAMES = 250
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic [DIGITS-1:0]     blink,
    output logic                  pending,
    output logic                  frame_tick,
    output logic [7:0]            SSEG_CA,
    output logic [DIGITS-1:0]     SSEG_AN
);

    localparam int unsigned DIV = (SIM != 0) ? SIM_DIV : SCAN_DIV;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned BW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic {
        PH_SCAN,
        PH_GUARD
    } phase_t;

    phase_t              phase_q, phase_d;
    logic [CW-1:0]       presc_q;
    logic                scan_tick;
    logic                light;
    logic [IW-1:0]       idx_q;
    logic [BW-1:0]       bcnt_q;
    logic                blink_phase_q;

    logic [4*DIGITS-1:0] stg_data, disp_data;
    logic [DIGITS-1:0]   stg_dp, stg_blank, stg_blink;
    logic [DIGITS-1:0]   disp_dp, disp_blank, disp_blink;

    logic [3:0]          nib;
    logic                cur_dp, cur_blank, cur_blink;
    logic [DIGITS-1:0]   an_lit;
    logic [7:0]          ca_lit;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_to_seg = 7'b1000000;
            4'h1: hex_to_seg = 7'b1111001;
            4'h2: hex_to_seg = 7'b0100100;
            4'h3: hex_to_seg = 7'b0110000;
            4'h4: hex_to_seg = 7'b0011001;
            4'h5: hex_to_seg = 7'b0010010;
            4'h6: hex_to_seg = 7'b0000010;
            4'h7: hex_to_seg = 7'b1111000;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0010000;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b0000011;
            4'hC: hex_to_seg = 7'b1000110;
            4'hD: hex_to_seg = 7'b0100001;
            4'hE: hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    assign scan_tick = (presc_q == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (scan_tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_SCAN;
        end else begin
            phase_q <= phase_d;
        end
    end

    // One dead-time cycle follows every scan_tick before the next anode is driven.
    always_comb begin
        phase_d = phase_q;
        light   = 1'b0;
        case (phase_q)
            PH_SCAN:  if (scan_tick) phase_d = PH_GUARD;
            PH_GUARD: begin
                light   = 1'b1;
                phase_d = PH_SCAN;
            end
            default:  phase_d = PH_SCAN;
        endcase
    end

    always_comb begin
        nib       = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_blink = 1'b0;
        an_lit    = '1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                nib       = disp_data[4*k +: 4];
                cur_dp    = disp_dp[k];
                cur_blank = disp_blank[k];
                cur_blink = disp_blink[k];
                an_lit[k] = 1'b0;
            end
        end
        ca_lit = (cur_blank || (cur_blink && blink_phase_q)) ? 8'hFF : {~cur_dp, hex_to_seg(nib)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SSEG_AN    <= '1;
            SSEG_CA    <= 8'hFF;
            idx_q      <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (scan_tick) begin
                SSEG_AN <= '1;
                SSEG_CA <= 8'hFF;
            end else if (light) begin
                SSEG_AN <= an_lit;
                SSEG_CA <= ca_lit;
                if (idx_q == IW'(DIGITS - 1)) begin
                    idx_q      <= '0;
                    frame_tick <= 1'b1;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    // A load landing in the commit cycle bypasses staging straight into the display set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= 1'b0;
            stg_data   <= '0;
            stg_dp     <= '0;
            stg_blank  <= '0;
            stg_blink  <= '0;
            disp_data  <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
            disp_blink <= '0;
        end else if (frame_tick) begin
            pending <= 1'b0;
            if (load) begin
                disp_data  <= data;
                disp_dp    <= dp;
                disp_blank <= blank;
                disp_blink <= blink;
            end else if (pending) begin
                disp_data  <= stg_data;
                disp_dp    <= stg_dp;
                disp_blank <= stg_blank;
                disp_blink <= stg_blink;
            end
        end else if (load) begin
            pending   <= 1'b1;
            stg_data  <= data;
            stg_dp    <= dp;
            stg_blank <= blank;
            stg_blink <= blink;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q        <= '0;
            blink_phase_q <= 1'b0;
        end else if (frame_tick) begin
            if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
                bcnt_q        <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                bcnt_q <= bcnt_q + 1'b1;
            end
        end
    end

endmodule
